regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data width of every write-data path.
REQ-002 Parameter REGBITS, default 5: register address width, giving 2^REGBITS registers.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 stall  input  1  when high, no request is granted this cycle.
REQ-006 a_valid  input  1  requester A has a write pending.
REQ-007 a_wa  input  REGBITS  requester A destination register.
REQ-008 a_wd  input  WIDTH  requester A write data.
REQ-009 a_ready  output  1  requester A is granted this cycle; combinational.
REQ-010 b_valid, b_wa, b_wd, b_ready SHALL mirror REQ-006..REQ-009 for requester B.
REQ-011 regwrite  output  1  registered write enable to the register file.
REQ-012 wa  output  REGBITS  registered write address to the register file.
REQ-013 wd  output  WIDTH  registered write data to the register file.
REQ-014 q_addr  input  REGBITS  bypass query address.
REQ-015 q_hit  output  1  combinational: the write stage holds an enabled write to q_addr.
REQ-016 q_data  output  WIDTH  combinational: equals wd when q_hit=1, else zero.
REQ-017 last_b  output  1  registered: 1 if the most recent grant went to B.

Function
REQ-018 A transfer SHALL occur on a requester when its valid and ready are both 1 at a rising clk edge.
REQ-019 At most one of a_ready and b_ready SHALL be 1 in any cycle.
REQ-020 With stall=0 and exactly one requester valid, that requester's ready SHALL be 1 in the same cycle.
REQ-021 With stall=0 and both requesters valid, ready SHALL go to the requester named by the round-robin pointer.
REQ-022 After every transfer, the pointer SHALL move to the non-granted requester; with no transfer, the pointer SHALL hold.
REQ-023 With stall=1, a_ready and b_ready SHALL both be 0, and the pointer SHALL hold.
REQ-024 One cycle after a transfer, wa/wd SHALL equal the granted request's address and data.
REQ-025 One cycle after a transfer, regwrite SHALL be 1 unless the granted address is 0.
REQ-026 A transfer with address 0 SHALL be consumed (ready=1) but SHALL produce regwrite=0.
REQ-027 In any cycle without a transfer, regwrite SHALL be 0 on the next cycle; wa and wd SHALL hold their previous values.
REQ-028 Latency from accepted request to regwrite assertion SHALL be exactly 1 cycle; sustained throughput SHALL be one write per cycle.
REQ-029 q_hit SHALL equal regwrite AND (q_addr == wa), so q_addr=0 never hits.
REQ-030 A ready signal SHALL depend only on valid, stall and pointer, never on wa/wd or q_addr.
REQ-031 Requesters SHALL hold valid, address and data stable until accepted; the arbiter need not detect violations.

Reset
REQ-032 While reset=1 at a clk edge: regwrite=0, wa=0, wd=0, last_b=0, and the pointer SHALL select A.
REQ-033 While reset=1, a_ready and b_ready SHALL be 0, and no transfer SHALL occur.
REQ-034 A transfer in flight when reset asserts SHALL be discarded: regwrite=0 in the cycle after reset is sampled.
REQ-035 The first cycle with reset=0 SHALL arbitrate normally, with A preferred.

Verification
REQ-036 Reset, then A and B both valid (A: r3=0x11, B: r4=0x22) for 2 cycles -> cycle 1: a_ready=1, then regwrite/wa=3/wd=0x11; cycle 2: b_ready=1, then wa=4/wd=0x22, last_b=1.
REQ-037 A and B continuously valid for 6 cycles -> grants strictly alternate A,B,A,B,A,B, and regwrite=1 in each of the following 6 cycles.
REQ-038 B valid with r0 data 0xFF -> b_ready=1, and next cycle regwrite=0; then q_addr=0 -> q_hit=0, q_data=0.
REQ-039 Both valid with stall=1 for 3 cycles, then stall=0 -> no ready during the stall; the first grant after the stall goes to the pointer-selected requester, and regwrite=0 during the stall plus 1 cycle.
REQ-040 A writes r7=0xDEADBEEF, next cycle q_addr=7 -> q_hit=1, q_data=0xDEADBEEF; the following idle cycle -> q_hit=0.
REQ-041 Transfer accepted, with reset asserted on the next edge -> regwrite=0, wa=0, wd=0 after that edge, and the pointer back at A.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two requesters share one register-file write port.
// Round-robin grant, one registered write per cycle, plus a bypass query.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   stall                 blocks every grant this cycle
//   a_valid/a_wa/a_wd     requester A write request
//   a_ready               A granted this cycle (combinational)
//   b_valid/b_wa/b_wd     requester B write request
//   b_ready               B granted this cycle (combinational)
//   regwrite/wa/wd        registered write port to the register file
//   q_addr                bypass query address
//   q_hit/q_data          bypass result (combinational)
//   last_b                most recent grant went to B
module regfile_wb_arbiter #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               a_valid,
  input  logic [REGBITS-1:0] a_wa,
  input  logic [WIDTH-1:0]   a_wd,
  output logic               a_ready,
  input  logic               b_valid,
  input  logic [REGBITS-1:0] b_wa,
  input  logic [WIDTH-1:0]   b_wd,
  output logic               b_ready,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  input  logic [REGBITS-1:0] q_addr,
  output logic               q_hit,
  output logic [WIDTH-1:0]   q_data,
  output logic               last_b
);

  // 1 means B wins the next contested cycle
  logic ptr_b;
  logic open;

  // Grants look only at valid, stall, reset and pointer
  assign open    = !reset && !stall;
  assign a_ready = open && a_valid && (!b_valid || !ptr_b);
  assign b_ready = open && b_valid && (!a_valid || ptr_b);

  // Register 0 is hardwired; its writes are consumed but never enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      last_b   <= 1'b0;
      ptr_b    <= 1'b0;
    end else if (a_ready) begin
      regwrite <= (a_wa != '0);
      wa       <= a_wa;
      wd       <= a_wd;
      last_b   <= 1'b0;
      ptr_b    <= 1'b1;
    end else if (b_ready) begin
      regwrite <= (b_wa != '0);
      wa       <= b_wa;
      wd       <= b_wd;
      last_b   <= 1'b1;
      ptr_b    <= 1'b0;
    end else begin
      regwrite <= 1'b0;
    end
  end

  assign q_hit  = regwrite && (q_addr == wa);
  assign q_data = q_hit ? wd : '0;

endmodule
